// File: rtl/costas_pkg.sv
// costas_pkg: shared DDS word widths, loader state encoding and tuning-word helper
package costas_pkg;
  localparam int DDS_FREQ_BITS = 32;
  localparam int DDS_CTRL_BITS = 8;
  localparam int DDS_WORD_BITS = 40;
  localparam longint unsigned DDS_REF_HZ = 64'd125_000_000;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_PPS, FQUD} dds_ld_state_t;
  function automatic logic [DDS_FREQ_BITS-1:0] freqword(input longint unsigned hz);
    longint unsigned t;
    t = ((hz << 32) + (DDS_REF_HZ >> 1)) / DDS_REF_HZ;
    return t[DDS_FREQ_BITS-1:0];
  endfunction
endpackage

// File: rtl/dds_serial_loader_if.sv
// dds_serial_loader_if: load request/word inputs plus DDS serial pins and status
interface dds_serial_loader_if;
  import costas_pkg::*;
  logic                     load_req;
  logic [DDS_FREQ_BITS-1:0] tuning_word;
  logic [DDS_CTRL_BITS-1:0] phase_word;
  logic                     dds_wclk;
  logic                     dds_data;
  logic                     fq_ud;
  logic                     busy;
  logic                     done;
  modport master (output load_req, tuning_word, phase_word, input dds_wclk, dds_data, fq_ud, busy, done);
  modport slave  (input load_req, tuning_word, phase_word, output dds_wclk, dds_data, fq_ud, busy, done);
endinterface

// File: rtl/dds_serial_loader_bit_timer.sv
// dds_bit_timer: CLK_DIV divider giving half-period and full-bit ticks for dds_wclk
module dds_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic half_tick,
  output logic bit_tick
);
  localparam int CW = $clog2(CLK_DIV) + 1;
  logic [CW-1:0] cnt;
  logic          hi;
  assign half_tick = en && cnt == CW'(CLK_DIV - 1);
  assign bit_tick  = half_tick && hi;
  always_ff @(posedge sys_clk) begin
    if (rst || clear) begin
      cnt <= '0;
      hi  <= 1'b0;
    end else if (half_tick) begin
      cnt <= '0;
      hi  <= ~hi;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/dds_serial_loader.sv
// dds_serial_loader: shifts {phase_word,tuning_word} LSB first to an AD9850, then pulses fq_ud; DDS_PPS_ALIGN_EN holds the commit for a pps rising edge
module dds_serial_loader
  import costas_pkg::*;
#(
  parameter int CLK_DIV           = 2,
  parameter int FQUD_PULSE_CYCLES = 4
) (
  input logic sys_clk,
  input logic rst,
`ifdef DDS_PPS_ALIGN_EN
  input logic pps,
`endif
  dds_serial_loader_if.slave bus
);
  localparam int FW = $clog2(FQUD_PULSE_CYCLES) + 1;
  if (CLK_DIV < 1 || FQUD_PULSE_CYCLES < 1) begin : g_bad_param
    $error("dds_serial_loader: CLK_DIV and FQUD_PULSE_CYCLES must be >= 1");
  end
`ifdef DDS_PPS_ALIGN_EN
  localparam dds_ld_state_t AFTER_SHIFT = WAIT_PPS;
  logic [2:0] pps_q;
  logic       pps_rise;
  assign pps_rise = pps_q[1] & ~pps_q[2];
  always_ff @(posedge sys_clk) begin
    if (rst) pps_q <= '0;
    else     pps_q <= {pps_q[1:0], pps};
  end
`else
  localparam dds_ld_state_t AFTER_SHIFT = FQUD;
  logic pps_rise;
  assign pps_rise = 1'b0;
`endif
  dds_ld_state_t            state, nxt;
  logic [DDS_WORD_BITS-1:0] sreg;
  logic [5:0]               bit_cnt;
  logic [FW-1:0]            fq_cnt;
  logic                     wclk_q, done_q;
  logic                     accept, half_tick, bit_tick, last_bit, fq_end;
  assign accept   = state == IDLE && bus.load_req;
  assign last_bit = bit_tick && bit_cnt == 6'd39;
  assign fq_end   = fq_cnt == FW'(FQUD_PULSE_CYCLES - 1);
  dds_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .clear    (accept),
    .en       (state == SHIFT),
    .half_tick(half_tick),
    .bit_tick (bit_tick)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = bus.load_req ? SHIFT : IDLE;
      SHIFT:    nxt = last_bit ? AFTER_SHIFT : SHIFT;
      WAIT_PPS: nxt = pps_rise ? FQUD : WAIT_PPS;
      FQUD:     nxt = fq_end ? IDLE : FQUD;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      fq_cnt  <= '0;
      wclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= nxt;
      sreg    <= accept ? {bus.phase_word, bus.tuning_word} : bit_tick ? sreg >> 1 : sreg;
      bit_cnt <= accept ? 6'd0 : bit_tick ? bit_cnt + 6'd1 : bit_cnt;
      fq_cnt  <= state == FQUD ? fq_cnt + 1'b1 : '0;
      wclk_q  <= accept ? 1'b0 : (state == SHIFT && half_tick) ? ~wclk_q : wclk_q;
      done_q  <= state == FQUD && fq_end;
    end
  end
  assign bus.dds_wclk = wclk_q;
  assign bus.dds_data = state == SHIFT && sreg[0];
  assign bus.fq_ud    = state == FQUD;
  assign bus.busy     = state != IDLE;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_dds_serial_loader.sv
// tb_dds_serial_loader: directed vector table plus reset/abort/back-to-back sequences
module tb_dds_serial_loader;
  import costas_pkg::*;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  dds_serial_loader_if bus ();
  dds_serial_loader #(.CLK_DIV(2), .FQUD_PULSE_CYCLES(4)) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );
  always #5 sys_clk = ~sys_clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  typedef struct {
    logic [31:0] tw;
    logic [7:0]  pw;
    bit          inject;
  } vec_t;
  vec_t vecs[4];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic xfer(input logic [31:0] tw, input logic [7:0] pw, input bit hold, input bit inject,
                      output logic [39:0] got, output int rises, output int fq_first,
                      output int fq_last, output int done_c, output bit bad);
    bit prev;
    bus.tuning_word = tw;
    bus.phase_word  = pw;
    bus.load_req    = 1'b1;
    @(posedge sys_clk); #1;
    if (!hold) bus.load_req = 1'b0;
    got = '0; rises = 0; fq_first = -1; fq_last = -1; done_c = -1; bad = 0; prev = 0;
    for (int c = 1; c <= 400 && done_c < 0; c++) begin
      if (bus.dds_wclk && !prev) begin
        if (rises < 40) got[rises] = bus.dds_data;
        rises++;
      end
      prev = bus.dds_wclk;
      if (bus.fq_ud) begin
        if (fq_first < 0) fq_first = c;
        fq_last = c;
        if (bus.dds_data || bus.dds_wclk) bad = 1;
      end
      if (bus.done) begin
        done_c = c;
        if (bus.busy) bad = 1;
      end else if (!bus.busy) bad = 1;
      if (inject && c == 50) begin
        bus.tuning_word = ~tw;
        bus.phase_word  = ~pw;
        bus.load_req    = 1'b1;
      end else if (inject && c == 51) bus.load_req = 1'b0;
      if (done_c < 0) begin @(posedge sys_clk); #1; end
    end
  endtask
  task automatic run_chk(input string name, input logic [31:0] tw, input logic [7:0] pw,
                         input bit hold, input bit inject);
    logic [39:0] got;
    int rises, fq_first, fq_last, done_c;
    bit bad;
    xfer(tw, pw, hold, inject, got, rises, fq_first, fq_last, done_c, bad);
    chk({name, "_rises"}, 64'(rises), 64'd40);
    chk({name, "_word"}, 64'(got), 64'({pw, tw}));
    chk({name, "_fq_first"}, 64'(fq_first), 64'd161);
    chk({name, "_fq_last"}, 64'(fq_last), 64'd164);
    chk({name, "_done"}, 64'(done_c), 64'd165);
    chk({name, "_busy_pins"}, 64'(bad), 64'd0);
  endtask
  initial begin
    bit prev, any_fq;
    int r;
    vecs[0] = '{32'h00029F17, 8'h00, 1'b0};
    vecs[1] = '{freqword(64'd1_000_000), 8'hA5, 1'b0};
    vecs[2] = '{32'h12345678, 8'h81, 1'b1};
    vecs[3] = '{32'h80000001, 8'h3C, 1'b0};
    bus.load_req = 1'b1;
    bus.tuning_word = 32'hDEADBEEF;
    bus.phase_word = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("reset_outs_%0d", i),
          64'({bus.busy, bus.done, bus.fq_ud, bus.dds_wclk, bus.dds_data}), 64'd0);
    end
    bus.load_req = 1'b0;
    rst = 1'b0;
    @(posedge sys_clk); #1;
    chk("freqword_5khz", 64'(freqword(64'd5000)), 64'h00029F17);
    for (int i = 0; i < 4; i++)
      run_chk($sformatf("vec%0d", i), vecs[i].tw, vecs[i].pw, 1'b0, vecs[i].inject);
    bus.tuning_word = 32'hCAFEF00D;
    bus.phase_word = 8'h5A;
    bus.load_req = 1'b1;
    @(posedge sys_clk); #1;
    bus.load_req = 1'b0;
    r = 0; prev = 0;
    for (int c = 0; c < 200 && r < 10; c++) begin
      if (bus.dds_wclk && !prev) r++;
      prev = bus.dds_wclk;
      if (r < 10) begin @(posedge sys_clk); #1; end
    end
    chk("abort_rise10", 64'(r), 64'd10);
    rst = 1'b1;
    @(posedge sys_clk); #1;
    chk("abort_outs", 64'({bus.busy, bus.done, bus.fq_ud, bus.dds_wclk, bus.dds_data}), 64'd0);
    rst = 1'b0;
    any_fq = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge sys_clk); #1;
      any_fq |= bus.fq_ud | bus.busy;
    end
    chk("abort_no_fqud", 64'(any_fq), 64'd0);
    run_chk("after_abort", vecs[0].tw, vecs[0].pw, 1'b0, 1'b0);
    run_chk("b2b_ones", 32'hFFFFFFFF, 8'h00, 1'b1, 1'b0);
    run_chk("b2b_zero", 32'h00000000, 8'h00, 1'b1, 1'b0);
    bus.load_req = 1'b0;
    @(posedge sys_clk); #1;
    chk("idle_after_b2b", 64'({bus.busy, bus.done, bus.fq_ud}), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
